// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers up to DEPTH
// returned instructions with their PCs, and flushes/drops in-flight data on redirect.
module inst_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] ADDR_INIT = 32'h0040_0000,
  parameter logic [31:0] INST_NOP  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        take,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic        busy
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  localparam logic [CW1-1:0] DEPTH_W = CW1'(DEPTH);
  localparam logic [CW-1:0]  ZERO_C  = CW'(0);
  localparam logic [CW-1:0]  ONE_C   = CW'(1);
  localparam logic [PW-1:0]  ZERO_P  = PW'(0);
  localparam logic [PW-1:0]  ONE_P   = PW'(1);
  localparam logic [31:0]    WORD_B  = 32'd4;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [31:0]   r_inst_q [DEPTH];
  logic [31:0]   r_pc_q   [DEPTH];

  logic          w_credit_ok;
  logic          w_issue;
  logic          w_resp_ok;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;

  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   w_resp_pc_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] w_drop_cnt_nxt;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;

  // Request credit and event qualification; responses with nothing outstanding are ignored.
  always_comb begin
    w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_W;
    mem_req     = !reset && !redirect && w_credit_ok;
    w_issue     = mem_req && mem_ready;
    w_resp_ok   = mem_rvalid && (r_outstanding != ZERO_C);
    w_push      = w_resp_ok && !redirect && (r_drop_cnt == ZERO_C);
    w_drop      = w_resp_ok && !redirect && (r_drop_cnt != ZERO_C);
    w_pop       = take && (r_count != ZERO_C) && !redirect;
  end

  // Next-state computation; redirect overrides issue, push and pop.
  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_resp_pc_nxt     = r_resp_pc;
    w_count_nxt       = r_count;
    w_outstanding_nxt = r_outstanding;
    w_drop_cnt_nxt    = r_drop_cnt;
    w_head_nxt        = r_head;
    w_tail_nxt        = r_tail;

    if (redirect) begin
      w_fetch_pc_nxt = redirect_pc;
      w_resp_pc_nxt  = redirect_pc;
      w_count_nxt    = ZERO_C;
      w_head_nxt     = ZERO_P;
      w_tail_nxt     = ZERO_P;
      if (w_resp_ok) begin
        w_outstanding_nxt = r_outstanding - ONE_C;
      end else begin
        w_outstanding_nxt = r_outstanding;
      end
      // Everything still in flight after this cycle belongs to the old stream.
      w_drop_cnt_nxt = w_outstanding_nxt;
    end else begin
      if (w_issue) begin
        w_fetch_pc_nxt = r_fetch_pc + WORD_B;
      end else begin
        w_fetch_pc_nxt = r_fetch_pc;
      end

      case ({w_issue, w_resp_ok})
        2'b10:   w_outstanding_nxt = r_outstanding + ONE_C;
        2'b01:   w_outstanding_nxt = r_outstanding - ONE_C;
        default: w_outstanding_nxt = r_outstanding;
      endcase

      if (w_drop) begin
        w_drop_cnt_nxt = r_drop_cnt - ONE_C;
      end else begin
        w_drop_cnt_nxt = r_drop_cnt;
      end

      if (w_push) begin
        w_resp_pc_nxt = r_resp_pc + WORD_B;
        w_tail_nxt    = r_tail + ONE_P;
      end else begin
        w_resp_pc_nxt = r_resp_pc;
        w_tail_nxt    = r_tail;
      end

      if (w_pop) begin
        w_head_nxt = r_head + ONE_P;
      end else begin
        w_head_nxt = r_head;
      end

      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + ONE_C;
        2'b01:   w_count_nxt = r_count - ONE_C;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= ADDR_INIT;
      r_resp_pc     <= ADDR_INIT;
      r_count       <= ZERO_C;
      r_outstanding <= ZERO_C;
      r_drop_cnt    <= ZERO_C;
      r_head        <= ZERO_P;
      r_tail        <= ZERO_P;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
      r_head        <= w_head_nxt;
      r_tail        <= w_tail_nxt;
    end
  end

  // Entry storage: instruction word and its PC written together at the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_q[i] <= INST_NOP;
        r_pc_q[i]   <= ADDR_INIT;
      end
    end else if (w_push) begin
      r_inst_q[r_tail] <= mem_rdata;
      r_pc_q[r_tail]   <= r_resp_pc;
    end else begin
      r_inst_q[r_tail] <= r_inst_q[r_tail];
      r_pc_q[r_tail]   <= r_pc_q[r_tail];
    end
  end

  // Head presentation; an empty queue shows NOP at the next expected PC.
  always_comb begin
    mem_addr  = r_fetch_pc;
    busy      = (r_outstanding != ZERO_C);
    out_valid = (r_count != ZERO_C);
    if (out_valid) begin
      out_inst = r_inst_q[r_head];
      out_pc   = r_pc_q[r_head];
    end else begin
      out_inst = INST_NOP;
      out_pc   = r_resp_pc;
    end
    out_npc = out_pc + WORD_B;
  end

endmodule
